// File: rtl/vending_machine_def.sv
// Shared definitions for the vending machine change path: widths, coin
// denominations and the change-dispense FSM state encoding.
package vending_machine_def;

   localparam int kTotalBits = 16;
   localparam int kNumCoins  = 3;

   // Coin denominations, indexed by select bit; index order is ascending value.
   localparam logic [kTotalBits-1:0] kCoin100  = kTotalBits'(100);
   localparam logic [kTotalBits-1:0] kCoin500  = kTotalBits'(500);
   localparam logic [kTotalBits-1:0] kCoin1000 = kTotalBits'(1000);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SELECT   = 2'd1,
      DISPENSE = 2'd2,
      DONE     = 2'd3
   } fsm_state_t;

   // Value of the coin behind select bit idx.
   function automatic logic [kTotalBits-1:0] coin_value(input int unsigned idx);
      case (idx)
         0:       coin_value = kCoin100;
         1:       coin_value = kCoin500;
         2:       coin_value = kCoin1000;
         default: coin_value = '0;
      endcase
   endfunction

endpackage

// File: rtl/coin_select.sv
// Combinational picker: the largest coin that still fits the remaining
// balance and whose hopper is neither empty nor jammed.
module coin_select
   import vending_machine_def::*;
(
   input  logic [kTotalBits-1:0] remaining,
   input  logic [kNumCoins-1:0]  blocked,
   output logic [kNumCoins-1:0]  sel,
   output logic [kTotalBits-1:0] value,
   output logic                  found
);

   logic [kNumCoins-1:0] eligible;

   generate
      for (genvar gi = 0; gi < kNumCoins; gi++) begin : g_elig
         assign eligible[gi] = ~blocked[gi] && (coin_value(gi) <= remaining);
      end
   endgenerate

   // Scan upward so the highest eligible index (largest value) wins.
   always_comb begin
      sel   = '0;
      value = '0;
      found = 1'b0;
      for (int i = 0; i < kNumCoins; i++) begin
         if (eligible[i]) begin
            sel    = '0;
            sel[i] = 1'b1;
            value  = coin_value(i);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change dispenser: on a return/expiry request, pays out the sampled balance
// coin by coin (largest first) through a request/acknowledge hopper
// handshake, marking hoppers that never acknowledge as jammed.
module change_dispense_ctrl
   import vending_machine_def::*;
#(
   parameter int kAckTimeout = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_trigger_return,
   input  logic                  i_wait_expired,
   input  logic [kTotalBits-1:0] current_total,
   input  logic [kNumCoins-1:0]  i_coin_empty,
   input  logic                  i_coin_ack,
   output logic                  o_coin_req,
   output logic [kNumCoins-1:0]  o_coin_sel,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [kTotalBits-1:0] o_dispensed,
   output logic [kTotalBits-1:0] o_residual
);

   // Counter only needs to reach kAckTimeout-1; that count is the last wait cycle.
   localparam int kCntBits = (kAckTimeout > 1) ? $clog2(kAckTimeout) : 1;
   localparam logic [kCntBits-1:0] kCntLast = kCntBits'(kAckTimeout - 1);

   fsm_state_t state_reg, state_next;

   logic [kTotalBits-1:0] remaining_reg, remaining_next;
   logic [kTotalBits-1:0] dispensed_reg, dispensed_next;
   logic [kTotalBits-1:0] residual_reg, residual_next;
   logic [kTotalBits-1:0] coin_val_reg, coin_val_next;
   logic [kNumCoins-1:0]  jam_reg, jam_next;
   logic [kNumCoins-1:0]  coin_sel_reg, coin_sel_next;
   logic [kCntBits-1:0]   ack_cnt_reg, ack_cnt_next;
   logic                  coin_req_reg, coin_req_next;
   logic                  busy_reg, busy_next;
   logic                  done_reg, done_next;

   logic [kNumCoins-1:0]  pick_sel;
   logic [kTotalBits-1:0] pick_value;
   logic                  pick_found;

   logic trigger;
   logic ack_hit;
   logic timeout_hit;

   assign trigger     = i_trigger_return | i_wait_expired;
   // Acks count only while a request is actually on the wire.
   assign ack_hit     = (state_reg == DISPENSE) && coin_req_reg && i_coin_ack;
   assign timeout_hit = (state_reg == DISPENSE) && !ack_hit && (ack_cnt_reg == kCntLast);

   coin_select u_coin_select (
      .remaining (remaining_reg),
      .blocked   (i_coin_empty | jam_reg),
      .sel       (pick_sel),
      .value     (pick_value),
      .found     (pick_found)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:     if (trigger) state_next = SELECT;
         SELECT:   state_next = pick_found ? DISPENSE : DONE;
         DISPENSE: if (ack_hit || timeout_hit) state_next = SELECT;
         DONE:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Output and datapath next values; every output leaves a flop.
   always_comb begin
      remaining_next = remaining_reg;
      dispensed_next = dispensed_reg;
      residual_next  = residual_reg;
      coin_val_next  = coin_val_reg;
      jam_next       = jam_reg;
      coin_sel_next  = coin_sel_reg;
      ack_cnt_next   = ack_cnt_reg;
      coin_req_next  = coin_req_reg;
      busy_next      = busy_reg;
      done_next      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (trigger) begin
               remaining_next = current_total;
               dispensed_next = '0;
               residual_next  = '0;
               jam_next       = '0;
               busy_next      = 1'b1;
            end
         end
         SELECT: begin
            if (pick_found) begin
               coin_req_next = 1'b1;
               coin_sel_next = pick_sel;
               coin_val_next = pick_value;
               ack_cnt_next  = '0;
            end
         end
         DISPENSE: begin
            if (ack_hit) begin
               // coin_select only offers coins that fit, so this cannot wrap.
               remaining_next = remaining_reg - coin_val_reg;
               dispensed_next = dispensed_reg + coin_val_reg;
               coin_req_next  = 1'b0;
               coin_sel_next  = '0;
            end else if (timeout_hit) begin
               jam_next      = jam_reg | coin_sel_reg;
               coin_req_next = 1'b0;
               coin_sel_next = '0;
            end else begin
               ack_cnt_next = ack_cnt_reg + 1'b1;
            end
         end
         DONE: begin
            done_next     = 1'b1;
            residual_next = remaining_reg;
            busy_next     = 1'b0;
         end
         default: begin
            coin_req_next = 1'b0;
            coin_sel_next = '0;
         end
      endcase
   end

   // Datapath and output registers; reset drops everything mid-transaction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         remaining_reg <= '0;
         dispensed_reg <= '0;
         residual_reg  <= '0;
         coin_val_reg  <= '0;
         jam_reg       <= '0;
         coin_sel_reg  <= '0;
         ack_cnt_reg   <= '0;
         coin_req_reg  <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         remaining_reg <= remaining_next;
         dispensed_reg <= dispensed_next;
         residual_reg  <= residual_next;
         coin_val_reg  <= coin_val_next;
         jam_reg       <= jam_next;
         coin_sel_reg  <= coin_sel_next;
         ack_cnt_reg   <= ack_cnt_next;
         coin_req_reg  <= coin_req_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
      end
   end

   assign o_coin_req  = coin_req_reg;
   assign o_coin_sel  = coin_sel_reg;
   assign o_busy      = busy_reg;
   assign o_done      = done_reg;
   assign o_dispensed = dispensed_reg;
   assign o_residual  = residual_reg;

endmodule

// File: doc/change_dispense_ctrl.md
CHANGE_DISPENSE_CTRL -- requirements
Module: change_dispense_ctrl

Interface
REQ-001 SHALL have parameter kAckTimeout, default 16: cycles to wait for hopper acknowledge before the coin is declared jammed.
REQ-002 SHALL take kTotalBits, kNumCoins and coin values 100/500/1000 (bit0/bit1/bit2) from vending_machine_def.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port i_trigger_return, input, 1: return-button request.
REQ-006 SHALL have port i_wait_expired, input, 1: wait-time expiry request.
REQ-007 SHALL have port current_total, input, kTotalBits: balance to refund, sampled only at transaction start.
REQ-008 SHALL have port i_coin_empty, input, kNumCoins: per-coin hopper empty flags.
REQ-009 SHALL have port i_coin_ack, input, 1: hopper has dropped the requested coin.
REQ-010 SHALL have port o_coin_req, output, 1: dispense request to hopper.
REQ-011 SHALL have port o_coin_sel, output, kNumCoins: one-hot coin select, valid while o_coin_req=1.
REQ-012 SHALL have port o_busy, output, 1: transaction in progress.
REQ-013 SHALL have port o_done, output, 1: one-cycle completion pulse.
REQ-014 SHALL have port o_dispensed, output, kTotalBits: amount paid out in the current or last transaction.
REQ-015 SHALL have port o_residual, output, kTotalBits: undispensed remainder, valid from o_done onward.

Function
REQ-016 SHALL implement FSM states IDLE, SELECT, DISPENSE and DONE.
REQ-017 SHALL leave IDLE only on (i_trigger_return | i_wait_expired) at a clock edge: load remaining=current_total, clear o_dispensed and jam flags, go to SELECT; o_busy=1 from the next cycle.
REQ-018 SHALL treat triggers arriving while not in IDLE as ignored; simultaneous return and expiry SHALL start one transaction.
REQ-019 SHALL, in SELECT, choose the largest coin with value <= remaining, hopper not empty and not jammed; if one exists, go to DISPENSE with o_coin_sel registered; otherwise go to DONE.
REQ-020 SHALL, in DISPENSE, hold o_coin_req=1 and o_coin_sel stable until ack or timeout; the first o_coin_req SHALL appear 2 cycles after the trigger edge.
REQ-021 SHALL, on an edge with o_coin_req & i_coin_ack, subtract the coin value from remaining, add it to o_dispensed, and return to SELECT; o_coin_req SHALL be low for at least one cycle between coins.
REQ-022 SHALL count DISPENSE cycles; at kAckTimeout cycles without ack, set that coin's jam flag, leave remaining unchanged, and return to SELECT.
REQ-023 SHALL ignore i_coin_ack outside DISPENSE.
REQ-024 SHALL, in DONE, pulse o_done for 1 cycle, set o_residual=remaining, deassert o_busy, and return to IDLE.
REQ-025 SHALL hold o_dispensed and o_residual until the next transaction start.
REQ-026 SHALL perform all arithmetic unsigned in kTotalBits; remaining SHALL never underflow because REQ-019 guarantees value <= remaining.
REQ-027 SHALL complete a transaction with remaining=0 or remaining<100 in IDLE->SELECT->DONE with no o_coin_req.

Reset
REQ-028 SHALL, on reset assertion and asynchronously, force state=IDLE, o_coin_req=0, o_coin_sel=0, o_busy=0, o_done=0, o_dispensed=0, o_residual=0, and clear the ack counter and jam flags.
REQ-029 SHALL abandon any transaction in progress when reset is asserted; no partial update SHALL survive reset.

Structure
REQ-030 SHALL place coin values, kNumCoins, kTotalBits and the FSM state encoding in vending_machine_def.
REQ-031 SHALL implement the largest-eligible-coin choice as a combinational sub-module coin_select (inputs remaining, empty|jam mask; outputs one-hot select, value, found).

Verification
REQ-032 SHALL cover: total 1600, hoppers full, ack 1 cycle after req -> coins 1000,500,100; o_dispensed=1600; o_residual=0; one o_done pulse.
REQ-033 SHALL cover: total 700 -> coins 500,100,100; o_dispensed=700; o_residual=0.
REQ-034 SHALL cover: total 1000, i_coin_empty[2]=1 -> coins 500,500; no 1000 req.
REQ-035 SHALL cover: total 600, 500-coin never acked -> req held exactly 16 cycles, then six 100 coins; o_dispensed=600.
REQ-036 SHALL cover: total 50 -> no o_coin_req; o_done 3 cycles after trigger; o_residual=50; also a trigger during busy is ignored.
REQ-037 SHALL cover: reset asserted mid-DISPENSE -> o_coin_req and o_busy low in the same cycle, before the next clock edge; the next trigger starts cleanly.
